// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - two-stage RISC-V instruction packer with immediate range checking
module imm_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_err,
    output logic [15:0] err_count
);

    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_REG    = 7'b0110011;
    localparam logic [31:0] NOP_INST  = 32'h00000013;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_BAD
    } fmt_e;

    // True when v[63:msb] are all equal, i.e. v survives truncation to msb+1 signed bits.
    function automatic logic sext_fits(input logic [63:0] v, input int unsigned msb);
        logic [63:0] t;
        t = $signed(v) >>> msb;
        return (t == '0) || (t == '1);
    endfunction

    logic        s1_valid_q,  s1_valid_d;
    logic [6:0]  s1_opcode_q, s1_opcode_d;
    logic [4:0]  s1_rd_q,     s1_rd_d;
    logic [4:0]  s1_rs1_q,    s1_rs1_d;
    logic [4:0]  s1_rs2_q,    s1_rs2_d;
    logic [2:0]  s1_funct3_q, s1_funct3_d;
    logic [6:0]  s1_funct7_q, s1_funct7_d;
    logic [63:0] s1_imm_q,    s1_imm_d;
    logic        s2_valid_q,  s2_valid_d;
    logic [31:0] s2_inst_q,   s2_inst_d;
    logic        s2_err_q,    s2_err_d;
    logic [15:0] err_count_q, err_count_d;

    logic        out_xfer;
    logic        s2_load;
    logic        in_xfer;
    fmt_e        fmt;
    logic [31:0] enc_inst;
    logic        enc_bad;

    assign out_xfer = s2_valid_q && out_ready;
    assign s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
    assign in_ready = !s1_valid_q || s2_load;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        fmt = FMT_BAD;
        case (s1_opcode_q)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_REG:                   fmt = FMT_R;
            default:                  fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        enc_bad  = 1'b0;
        enc_inst = NOP_INST;
        case (fmt)
            FMT_I: begin
                enc_bad  = !sext_fits(s1_imm_q, 11);
                enc_inst = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            end
            FMT_S: begin
                enc_bad  = !sext_fits(s1_imm_q, 11);
                enc_inst = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:0], s1_opcode_q};
            end
            FMT_B: begin
                enc_bad  = !sext_fits(s1_imm_q, 12) || s1_imm_q[0];
                enc_inst = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                            s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
            end
            FMT_U: begin
                enc_bad  = !sext_fits(s1_imm_q, 31) || (s1_imm_q[11:0] != 12'h000);
                enc_inst = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
            end
            FMT_J: begin
                enc_bad  = !sext_fits(s1_imm_q, 20) || s1_imm_q[0];
                enc_inst = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                            s1_rd_q, s1_opcode_q};
            end
            FMT_R: begin
                enc_bad  = 1'b0;
                enc_inst = {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
            end
            default: begin
                enc_bad  = 1'b1;
                enc_inst = NOP_INST;
            end
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_opcode_d = s1_opcode_q;
        s1_rd_d     = s1_rd_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_funct3_d = s1_funct3_q;
        s1_funct7_d = s1_funct7_q;
        s1_imm_d    = s1_imm_q;
        if (in_xfer) begin
            s1_valid_d  = 1'b1;
            s1_opcode_d = in_opcode;
            s1_rd_d     = in_rd;
            s1_rs1_d    = in_rs1;
            s1_rs2_d    = in_rs2;
            s1_funct3_d = in_funct3;
            s1_funct7_d = in_funct7;
            s1_imm_d    = in_imm;
        end else if (s2_load) begin
            s1_valid_d  = 1'b0;
        end
    end

    // A rejected word still travels as a NOP so downstream ordering is preserved.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_inst_d  = enc_bad ? NOP_INST : enc_inst;
            s2_err_d   = enc_bad;
        end else if (out_xfer) begin
            s2_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (out_xfer && s2_err_q && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_opcode_q <= 7'h0;
            s1_rd_q     <= 5'h0;
            s1_rs1_q    <= 5'h0;
            s1_rs2_q    <= 5'h0;
            s1_funct3_q <= 3'h0;
            s1_funct7_q <= 7'h0;
            s1_imm_q    <= 64'h0;
            s2_valid_q  <= 1'b0;
            s2_inst_q   <= 32'h0;
            s2_err_q    <= 1'b0;
            err_count_q <= 16'h0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_opcode_q <= s1_opcode_d;
            s1_rd_q     <= s1_rd_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_funct3_q <= s1_funct3_d;
            s1_funct7_q <= s1_funct7_d;
            s1_imm_q    <= s1_imm_d;
            s2_valid_q  <= s2_valid_d;
            s2_inst_q   <= s2_inst_d;
            s2_err_q    <= s2_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - directed-vector bench for imm_encoder
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [63:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [15:0] err_count;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q[$];

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    imm_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_word", out_inst, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("out_inst", out_inst, e[31:0]);
                check("out_err", out_err, e[32]);
            end
        end
    end

    task automatic add_vec(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [63:0] imm, input logic [31:0] inst, input logic err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.inst = inst; v.err = err;
        vecs.push_back(v);
    endtask

    task automatic send(input vec_t v);
        logic done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_rd     = v.rd;
        in_rs1    = v.rs1;
        in_rs2    = v.rs2;
        in_funct3 = v.f3;
        in_funct7 = v.f7;
        in_imm    = v.imm;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({v.err, v.inst});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) check("drain_timeout", 0, 1);
    endtask

    task automatic send_one(input logic [6:0] op, input logic [63:0] imm,
                            input logic [31:0] inst, input logic err);
        vec_t v;
        v.op = op; v.rd = 5'd1; v.rs1 = 5'd0; v.rs2 = 5'd0; v.f3 = 3'd0; v.f7 = 7'd0;
        v.imm = imm; v.inst = inst; v.err = err;
        send(v);
    endtask

    logic [31:0] bp_words [4];
    int          idx;
    logic [3:0]  vmask;
    logic        any_valid;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        bp_words[0] = 32'h002080B3; bp_words[1] = 32'h00208133;
        bp_words[2] = 32'h002081B3; bp_words[3] = 32'h00208233;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // addi x1,x0,-1 with latency observation
        in_valid = 1'b1; in_opcode = 7'b0010011; in_rd = 5'd1; in_imm = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1);
        exp_q.push_back({1'b0, 32'hFFF00093});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("lat_valid", out_valid, 1);
        check("lat_inst", out_inst, 32'hFFF00093);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        send_one(7'b0010011, 64'd2048, 32'h00000013, 1'b1);
        drain();
        check("err_count_1", err_count, 16'd1);
        send_one(7'b1111111, 64'd0, 32'h00000013, 1'b1);
        drain();
        check("err_count_2", err_count, 16'd2);

        add_vec(7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 64'd8, 32'h0021A423, 1'b0);
        add_vec(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -64'sd4, 32'hFE208EE3, 1'b0);
        add_vec(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 64'h12345000, 32'h123452B7, 1'b0);
        add_vec(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 64'h12345001, 32'h00000013, 1'b1);
        add_vec(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 64'd2047, 32'h7FF00093, 1'b0);
        add_vec(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, -64'sd2048, 32'h80000093, 1'b0);
        add_vec(7'b0100011, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, -64'sd1, 32'hFE21AFA3, 1'b0);
        add_vec(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 64'd3, 32'h00000013, 1'b1);
        add_vec(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 64'hFFFF_FFFF_8000_0000, 32'h800002B7, 1'b0);
        add_vec(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 64'h0000_0000_8000_0000, 32'h00000013, 1'b1);
        add_vec(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 64'h800, 32'h001000EF, 1'b0);
        add_vec(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -64'sd2, 32'hFFFFF06F, 1'b0);
        add_vec(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 64'h100000, 32'h00000013, 1'b1);
        add_vec(7'b1101111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -64'sd1048576, 32'h8000006F, 1'b0);
        add_vec(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 64'hDEADBEEF, 32'h002081B3, 1'b0);
        add_vec(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20, 64'h8000_0000_0000_0001, 32'h402081B3, 1'b0);
        add_vec(7'b0000011, 5'd4, 5'd6, 5'd0, 3'b010, 7'd0, -64'sd8, 32'hFF832203, 1'b0);
        add_vec(7'b1100111, 5'd0, 5'd1, 5'd0, 3'b000, 7'd0, 64'd0, 32'h00008067, 1'b0);
        add_vec(7'b0010111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 64'h1000, 32'h00001097, 1'b0);
        foreach (vecs[i]) send(vecs[i]);
        drain();
        check("err_count_table", err_count, 16'd6);

        // backpressure: 4 words offered while the output is stalled for 6 cycles
        idx = 0;
        vmask = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            out_ready = (cyc >= 6);
            if (idx < 4) begin
                in_valid = 1'b1; in_opcode = 7'b0110011; in_rd = 5'(idx + 1);
                in_rs1 = 5'd1; in_rs2 = 5'd2; in_funct3 = 3'd0; in_funct7 = 7'd0; in_imm = 64'd0;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc == 3) check("bp_in_ready_low", in_ready, 0);
            if (cyc == 5) begin
                check("bp_accepts", idx, 2);
                check("bp_hold_inst", out_inst, bp_words[0]);
            end
            if (cyc >= 6 && cyc <= 9) vmask[cyc - 6] = out_valid;
            if (cyc == 10) check("bp_drained", out_valid, 0);
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, bp_words[idx]});
                idx++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_stream", vmask, 4'hF);
        check("bp_accept_total", idx, 4);
        drain();

        // saturation of err_count
        @(negedge clk);
        force dut.err_count_q = 16'hFFFE;
        #1;
        release dut.err_count_q;
        @(posedge clk);
        #1;
        check("sat_preload", err_count, 16'hFFFE);
        send_one(7'b1111111, 64'd0, 32'h00000013, 1'b1);
        drain();
        check("sat_reach", err_count, 16'hFFFF);
        send_one(7'b1111111, 64'd0, 32'h00000013, 1'b1);
        drain();
        check("sat_hold", err_count, 16'hFFFF);

        // asynchronous reset with two words in flight
        out_ready = 1'b0;
        send_one(7'b0010011, 64'd5, 32'h00500093, 1'b0);
        send_one(7'b0010011, 64'd6, 32'h00600093, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_err_count", err_count, 16'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        any_valid = 1'b0;
        repeat (5) begin
            @(negedge clk);
            any_valid = any_valid | out_valid;
        end
        check("arst_no_stale", any_valid, 0);
        check("arst_count_after", err_count, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
